// File: rtl/bt_cmd_seq_if.sv
// Command handshake between the sequencer and the UART command sender.
interface bt_cmd_seq_if;
    logic       send;
    logic [4:0] cmd_start;
    logic [3:0] cmd_len;
    logic       resp_rcvd;

    modport master (output send, cmd_start, cmd_len, input resp_rcvd);
    modport slave  (input send, cmd_start, cmd_len, output resp_rcvd);
endinterface

// File: rtl/bt_cmd_seq.sv
// Bluetooth audio module bring-up and track-skip command sequencer.
// Resets and boots the module, sends two init commands, then forwards button presses.
module bt_cmd_seq #(
    parameter int         RST_CYCLES   = 65536,
    parameter int         BOOT_CYCLES  = 1048576,
    parameter int         RESP_TIMEOUT = 2000000,
    parameter logic [4:0] INIT1_ST     = 5'd0,
    parameter logic [3:0] INIT1_LEN    = 4'd6,
    parameter logic [4:0] INIT2_ST     = 5'd6,
    parameter logic [3:0] INIT2_LEN    = 4'd10,
    parameter logic [4:0] NEXT_ST      = 5'd16,
    parameter logic [3:0] NEXT_LEN     = 4'd4,
    parameter logic [4:0] PREV_ST      = 5'd20,
    parameter logic [3:0] PREV_LEN     = 4'd4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          next_n,
    input  logic          prv_n,
    bt_cmd_seq_if.master  cmd,
    output logic          bt_rst_n,
    output logic          init_done,
    output logic          busy,
    output logic          cmd_err
);
    localparam int MAX_A = (RST_CYCLES > BOOT_CYCLES) ? RST_CYCLES : BOOT_CYCLES;
    localparam int MAX_C = (MAX_A > RESP_TIMEOUT) ? MAX_A : RESP_TIMEOUT;
    localparam int CNT_W = $clog2(MAX_C) + 1;
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(RESP_TIMEOUT - 1);

    typedef enum logic [2:0] {S_BT_RST, S_BOOT, S_SEND, S_WAIT, S_IDLE} state_t;
    typedef enum logic [1:0] {C_INIT1, C_INIT2, C_NEXT, C_PREV} cmd_t;

    state_t           state;
    cmd_t             cur, go_cmd;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic             retry, go, timeout, next_fall, prv_fall;
    logic [2:0]       nsync, psync;

    function automatic logic [8:0] rom(cmd_t c);
        case (c)
            C_INIT1: rom = {INIT1_ST, INIT1_LEN};
            C_INIT2: rom = {INIT2_ST, INIT2_LEN};
            C_NEXT:  rom = {NEXT_ST,  NEXT_LEN};
            default: rom = {PREV_ST,  PREV_LEN};
        endcase
    endfunction

    // Two sync stages, third stage only for the falling-edge compare.
    assign next_fall = nsync[2] & ~nsync[1];
    assign prv_fall  = psync[2] & ~psync[1];
    assign cnt_inc   = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    assign timeout   = (cnt >= TO_LAST);

    // Decides whether a new send is issued this cycle and which command it carries.
    always_comb begin
        go     = 1'b0;
        go_cmd = cur;
        case (state)
            S_BOOT: if (cnt >= BOOT_LAST) begin
                go     = 1'b1;
                go_cmd = C_INIT1;
            end
            S_WAIT: if (cmd.resp_rcvd || timeout) begin
                if (!cmd.resp_rcvd && !retry) begin
                    go = 1'b1;
                end else if (cur == C_INIT1) begin
                    go     = 1'b1;
                    go_cmd = C_INIT2;
                end
            end
            S_IDLE: if (next_fall) begin
                go     = 1'b1;
                go_cmd = C_NEXT;
            end else if (prv_fall) begin
                go     = 1'b1;
                go_cmd = C_PREV;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_BT_RST;
            cur           <= C_INIT1;
            cnt           <= '0;
            retry         <= 1'b0;
            nsync         <= 3'b111;
            psync         <= 3'b111;
            cmd.send      <= 1'b0;
            cmd.cmd_start <= '0;
            cmd.cmd_len   <= '0;
            bt_rst_n      <= 1'b0;
            init_done     <= 1'b0;
            busy          <= 1'b0;
            cmd_err       <= 1'b0;
        end else begin
            nsync    <= {nsync[1:0], next_n};
            psync    <= {psync[1:0], prv_n};
            cmd.send <= 1'b0;
            case (state)
                S_BT_RST: if (cnt >= RST_LAST) begin
                    bt_rst_n <= 1'b1;
                    cnt      <= '0;
                    state    <= S_BOOT;
                end else begin
                    cnt <= cnt_inc;
                end
                S_BOOT: cnt <= cnt_inc;
                S_SEND: begin
                    cnt   <= cnt_inc;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt_inc;
                    if (cmd.resp_rcvd || timeout) begin
                        if (cmd.resp_rcvd || retry) begin
                            retry <= 1'b0;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                            if (!cmd.resp_rcvd)  cmd_err   <= 1'b1;
                            if (cur == C_INIT2)  init_done <= 1'b1;
                        end else begin
                            retry <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            // A send overrides whatever the state branch chose above.
            if (go) begin
                state                          <= S_SEND;
                cur                            <= go_cmd;
                cnt                            <= '0;
                busy                           <= 1'b1;
                cmd.send                       <= 1'b1;
                {cmd.cmd_start, cmd.cmd_len}   <= rom(go_cmd);
            end
        end
    end
endmodule

// File: tb/tb_bt_cmd_seq.sv
// Directed bench for bt_cmd_seq with shortened reset/boot/timeout counts.
module tb_bt_cmd_seq;
    logic clk = 1'b0;
    logic rst_n, next_n, prv_n, bt_rst_n, init_done, busy, cmd_err;
    int   vectors = 0, errors = 0, sends = 0;
    logic [4:0] last_start;
    logic [3:0] last_len;

    bt_cmd_seq_if bus ();

    bt_cmd_seq #(.RST_CYCLES(4), .BOOT_CYCLES(8), .RESP_TIMEOUT(100)) dut (
        .clk(clk), .rst_n(rst_n), .next_n(next_n), .prv_n(prv_n), .cmd(bus),
        .bt_rst_n(bt_rst_n), .init_done(init_done), .busy(busy), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.send === 1'b1) begin
        sends++;
        last_start = bus.cmd_start;
        last_len   = bus.cmd_len;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_send(input int max, output int n);
        n = 0;
        while (bus.send !== 1'b1 && n < max) begin step(); n++; end
    endtask

    task automatic respond();
        bus.resp_rcvd = 1'b1;
        step();
        bus.resp_rcvd = 1'b0;
    endtask

    task automatic press(input bit do_next, input bit do_prev, output int at);
        at = 0;
        if (do_next) next_n = 1'b0;
        if (do_prev) prv_n = 1'b0;
        for (int i = 1; i <= 5; i++) begin step(); if (bus.send === 1'b1 && at == 0) at = i; end
        next_n = 1'b1;
        prv_n  = 1'b1;
        for (int i = 6; i <= 9; i++) begin step(); if (bus.send === 1'b1 && at == 0) at = i; end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; next_n = 1'b1; prv_n = 1'b1; bus.resp_rcvd = 1'b0;
        step(); step();
        vectors++; if (bus.send !== 1'b0) begin errors++; $display("FAIL rst_send got %b want 0", bus.send); end
        vectors++; if (bus.cmd_start !== 5'd0) begin errors++; $display("FAIL rst_start got %0d want 0", bus.cmd_start); end
        vectors++; if (bus.cmd_len !== 4'd0) begin errors++; $display("FAIL rst_len got %0d want 0", bus.cmd_len); end
        vectors++; if (bt_rst_n !== 1'b0) begin errors++; $display("FAIL rst_bt_rst_n got %b want 0", bt_rst_n); end
        vectors++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done got %b want 0", init_done); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        vectors++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL rst_cmd_err got %b want 0", cmd_err); end
    endtask

    task automatic test_init();
        int n;
        rst_n = 1'b1;
        step(); step(); step();
        vectors++; if (bt_rst_n !== 1'b0) begin errors++; $display("FAIL init_bt_rst_hold got %b want 0", bt_rst_n); end
        step();
        vectors++; if (bt_rst_n !== 1'b1) begin errors++; $display("FAIL init_bt_rst_rel got %b want 1", bt_rst_n); end
        wait_send(20, n);
        vectors++; if (n !== 8) begin errors++; $display("FAIL init_boot_wait got %0d want 8", n); end
        vectors++; if (bus.cmd_start !== 5'd0 || bus.cmd_len !== 4'd6) begin errors++; $display("FAIL init1_cmd got %0d/%0d want 0/6", bus.cmd_start, bus.cmd_len); end
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL init1_busy got %b want 1", busy); end
        step();
        vectors++; if (bus.send !== 1'b0) begin errors++; $display("FAIL init1_pulse got %b want 0", bus.send); end
        repeat (8) step();
        respond();
        vectors++; if (bus.send !== 1'b1 || bus.cmd_start !== 5'd6 || bus.cmd_len !== 4'd10) begin errors++; $display("FAIL init2_cmd got %b %0d/%0d want 1 6/10", bus.send, bus.cmd_start, bus.cmd_len); end
        vectors++; if (init_done !== 1'b0) begin errors++; $display("FAIL init2_early_done got %b want 0", init_done); end
        step();
        respond();
        vectors++; if (init_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL init_done got done=%b busy=%b want 1 0", init_done, busy); end
    endtask

    task automatic test_buttons();
        int at, s0;
        s0 = sends;
        press(1'b1, 1'b0, at);
        vectors++; if (at !== 3) begin errors++; $display("FAIL next_latency got %0d want 3", at); end
        vectors++; if (sends - s0 !== 1 || last_start !== 5'd16 || last_len !== 4'd4) begin errors++; $display("FAIL next_cmd got n=%0d %0d/%0d want 1 16/4", sends - s0, last_start, last_len); end
        respond();
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL next_busy got %b want 0", busy); end
        s0 = sends;
        press(1'b0, 1'b1, at);
        vectors++; if (at !== 3) begin errors++; $display("FAIL prev_latency got %0d want 3", at); end
        vectors++; if (sends - s0 !== 1 || last_start !== 5'd20 || last_len !== 4'd4) begin errors++; $display("FAIL prev_cmd got n=%0d %0d/%0d want 1 20/4", sends - s0, last_start, last_len); end
        respond();
    endtask

    task automatic test_drop_while_busy();
        int at, s0;
        press(1'b1, 1'b0, at);
        s0 = sends;
        press(1'b0, 1'b1, at);
        vectors++; if (at !== 0 || sends !== s0) begin errors++; $display("FAIL drop_in_wait got at=%0d extra=%0d want 0 0", at, sends - s0); end
        respond();
        repeat (10) step();
        vectors++; if (sends !== s0 || busy !== 1'b0) begin errors++; $display("FAIL drop_after_resp got extra=%0d busy=%b want 0 0", sends - s0, busy); end
    endtask

    task automatic test_both_pressed();
        int at, s0;
        s0 = sends;
        press(1'b1, 1'b1, at);
        vectors++; if (sends - s0 !== 1 || last_start !== 5'd16) begin errors++; $display("FAIL both_cmd got n=%0d start=%0d want 1 16", sends - s0, last_start); end
        respond();
    endtask

    task automatic test_timeout();
        int n;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        wait_send(30, n);
        vectors++; if (n !== 12 || bus.cmd_start !== 5'd0) begin errors++; $display("FAIL to_first got wait=%0d start=%0d want 12 0", n, bus.cmd_start); end
        step();
        wait_send(150, n);
        vectors++; if (n + 1 !== 100 || bus.cmd_start !== 5'd0 || bus.cmd_len !== 4'd6) begin errors++; $display("FAIL to_retry got gap=%0d %0d/%0d want 100 0/6", n + 1, bus.cmd_start, bus.cmd_len); end
        vectors++; if (cmd_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_retry_flags got err=%b busy=%b want 0 1", cmd_err, busy); end
        step();
        wait_send(150, n);
        vectors++; if (n + 1 !== 100 || bus.cmd_start !== 5'd6 || bus.cmd_len !== 4'd10) begin errors++; $display("FAIL to_give_up got gap=%0d %0d/%0d want 100 6/10", n + 1, bus.cmd_start, bus.cmd_len); end
        vectors++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL to_cmd_err got %b want 1", cmd_err); end
        respond();
        vectors++; if (init_done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_send_cycle_resp got done=%b busy=%b want 0 1", init_done, busy); end
        repeat (3) step();
        respond();
        vectors++; if (init_done !== 1'b1 || busy !== 1'b0 || cmd_err !== 1'b1) begin errors++; $display("FAIL to_final got done=%b busy=%b err=%b want 1 0 1", init_done, busy, cmd_err); end
    endtask

    task automatic test_reset_mid_wait();
        int at, n;
        press(1'b1, 1'b0, at);
        vectors++; if (busy !== 1'b1 || bus.cmd_start !== 5'd16) begin errors++; $display("FAIL mid_pre got busy=%b start=%0d want 1 16", busy, bus.cmd_start); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if ({bus.send, bus.cmd_start, bus.cmd_len, bt_rst_n, init_done, busy, cmd_err} !== 15'd0) begin errors++; $display("FAIL mid_reset got %b want all 0", {bus.send, bus.cmd_start, bus.cmd_len, bt_rst_n, init_done, busy, cmd_err}); end
        step();
        rst_n = 1'b1;
        step(); step(); step();
        vectors++; if (bt_rst_n !== 1'b0) begin errors++; $display("FAIL mid_restart_hold got %b want 0", bt_rst_n); end
        step();
        vectors++; if (bt_rst_n !== 1'b1) begin errors++; $display("FAIL mid_restart_rel got %b want 1", bt_rst_n); end
        wait_send(20, n);
        vectors++; if (n !== 8 || bus.cmd_start !== 5'd0 || bus.cmd_len !== 4'd6) begin errors++; $display("FAIL mid_restart_init1 got wait=%0d %0d/%0d want 8 0/6", n, bus.cmd_start, bus.cmd_len); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_buttons();
        test_drop_while_busy();
        test_both_pressed();
        test_timeout();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
